// File: rtl/gpu_ctrl_pkg.sv
// Shared types and constants for the 2D GPU control blocks.
package gpu_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    DECODE = 4'd1,
    PUSH   = 4'd2,
    GEN    = 4'd3,
    OUT    = 4'd4,
    POP    = 4'd5,
    DONE   = 4'd6,
    ERR    = 4'd7,
    FLUSH  = 4'd8
  } state_t;

  localparam int unsigned SHAPE_LINE   = 32'd0;
  localparam int unsigned SHAPE_POLY   = 32'd1;
  localparam int unsigned SHAPE_CIRCLE = 32'd3;

  localparam logic ENG_LINE = 1'b0;
  localparam logic ENG_ARC  = 1'b1;

endpackage

// File: rtl/shape_sequencer.sv
// Shape-to-primitive sequencer: pushes a shape's primitives into the FIFO, steps the
// line/arc engine per pixel, pops finished primitives and reports completion or error.
module shape_sequencer
  import gpu_ctrl_pkg::*;
#(
  parameter int SHAPE_ID_W = 4,
  parameter int MAX_SIDES  = 8,
  parameter int NUM_ARCS   = 8,
  parameter int SEL_W      = 4,
  localparam int SIDE_W    = $clog2(MAX_SIDES + 1),
  localparam int ARC_W     = $clog2(NUM_ARCS)
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  new_shape,
  input  logic [SHAPE_ID_W-1:0] shapeid,
  input  logic [SIDE_W-1:0]     num_sides,
  input  logic                  data_ready,
  input  logic                  data_sent,
  input  logic                  line_done,
  input  logic                  arc_done,
  input  logic                  abort,
  output logic                  prim_sel,
  output logic                  write,
  output logic                  read,
  output logic                  enable,
  output logic [SEL_W-1:0]      output_sel,
  output logic [ARC_W-1:0]      arc_idx,
  output logic                  busy,
  output logic                  shape_done,
  output logic                  shape_err
);

  state_t                state_r, state_s;
  logic [SHAPE_ID_W-1:0] shape_r;
  logic [SIDE_W-1:0]     sides_r;
  logic [SIDE_W-1:0]     n_r, n_s;
  logic [SIDE_W-1:0]     push_cnt_r;
  logic [SIDE_W-1:0]     side_cnt_r;
  logic [SIDE_W-1:0]     pending_r;
  logic [ARC_W-1:0]      arc_idx_r;
  logic                  is_line_s, is_poly_s, is_circle_s, prim_done_s;

  // Shape class decode and primitive-finished condition
  always_comb begin
    is_line_s   = (shape_r == SHAPE_ID_W'(SHAPE_LINE));
    is_poly_s   = (shape_r == SHAPE_ID_W'(SHAPE_POLY));
    is_circle_s = (shape_r == SHAPE_ID_W'(SHAPE_CIRCLE));
    if (is_circle_s) begin
      // only the wrap back to arc 0 ends a circle
      prim_done_s = arc_done && (arc_idx_r == ARC_W'(0));
    end else begin
      prim_done_s = line_done;
    end
  end

  // Next-state logic; abort overrides every active state
  always_comb begin
    state_s = state_r;
    n_s     = n_r;
    case (state_r)
      IDLE: begin
        if (new_shape) state_s = DECODE;
        else           state_s = IDLE;
      end
      DECODE: begin
        if (is_line_s || is_circle_s) begin
          n_s     = SIDE_W'(1);
          state_s = PUSH;
        end else if (is_poly_s && (sides_r >= SIDE_W'(3)) && (sides_r <= SIDE_W'(MAX_SIDES))) begin
          n_s     = sides_r;
          state_s = PUSH;
        end else begin
          state_s = ERR;
        end
      end
      PUSH: begin
        if (push_cnt_r == n_r - SIDE_W'(1)) state_s = GEN;
        else                                state_s = PUSH;
      end
      GEN: begin
        if (prim_done_s)     state_s = POP;
        else if (data_ready) state_s = OUT;
        else                 state_s = GEN;
      end
      OUT: begin
        if (data_sent) state_s = GEN;
        else           state_s = OUT;
      end
      POP: begin
        if (side_cnt_r == n_r - SIDE_W'(1)) state_s = DONE;
        else                                state_s = GEN;
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      FLUSH: begin
        if (pending_r == SIDE_W'(0)) state_s = IDLE;
        else                         state_s = FLUSH;
      end
      default: state_s = IDLE;
    endcase
    if (abort && (state_r inside {DECODE, PUSH, GEN, OUT, POP})) begin
      state_s = FLUSH;
    end else begin
      state_s = state_s;
    end
  end

  // Moore output decode from registered state and counters
  always_comb begin
    write      = (state_r == PUSH);
    read       = (state_r == POP) || ((state_r == FLUSH) && (pending_r != SIDE_W'(0)));
    enable     = (state_r == GEN);
    output_sel = (state_r == PUSH) ? SEL_W'(push_cnt_r) : SEL_W'(0);
    arc_idx    = arc_idx_r;
    busy       = (state_r != IDLE);
    shape_done = (state_r == DONE);
    shape_err  = (state_r == ERR);
    prim_sel   = (state_r != IDLE) && is_circle_s ? ENG_ARC : ENG_LINE;
  end

  // State register, command latch and primitive counters
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= IDLE;
      shape_r    <= SHAPE_ID_W'(0);
      sides_r    <= SIDE_W'(0);
      n_r        <= SIDE_W'(0);
      push_cnt_r <= SIDE_W'(0);
      side_cnt_r <= SIDE_W'(0);
      pending_r  <= SIDE_W'(0);
      arc_idx_r  <= ARC_W'(0);
    end else begin
      state_r   <= state_s;
      n_r       <= n_s;
      // FIFO occupancy follows the strobes actually issued, so abort mid-PUSH stays exact
      pending_r <= pending_r + SIDE_W'(write) - SIDE_W'(read);
      if ((state_r == IDLE) && new_shape) begin
        shape_r    <= shapeid;
        sides_r    <= num_sides;
        push_cnt_r <= SIDE_W'(0);
        side_cnt_r <= SIDE_W'(0);
        arc_idx_r  <= ARC_W'(0);
      end else begin
        if (write) push_cnt_r <= push_cnt_r + SIDE_W'(1);
        else       push_cnt_r <= push_cnt_r;
        if (state_r == POP) side_cnt_r <= side_cnt_r + SIDE_W'(1);
        else                side_cnt_r <= side_cnt_r;
        if ((state_r == OUT) && (state_s == GEN) && is_circle_s) arc_idx_r <= arc_idx_r + ARC_W'(1);
        else                                                     arc_idx_r <= arc_idx_r;
      end
    end
  end

endmodule

// File: tb/tb_shape_sequencer.sv
// Directed self-checking bench for shape_sequencer: line, polygon, circle, illegal
// commands, abort drain and asynchronous reset.
module tb_shape_sequencer;

  localparam int SHAPE_ID_W = 4;
  localparam int MAX_SIDES  = 8;
  localparam int NUM_ARCS   = 8;
  localparam int SEL_W      = 4;
  localparam int SIDE_W     = 4;
  localparam int ARC_W      = 3;

  logic                  clk = 1'b0;
  logic                  nreset = 1'b0;
  logic                  new_shape = 1'b0;
  logic [SHAPE_ID_W-1:0] shapeid = '0;
  logic [SIDE_W-1:0]     num_sides = '0;
  logic                  data_ready = 1'b0, data_sent = 1'b0, line_done = 1'b0, arc_done = 1'b0, abort = 1'b0;
  logic                  prim_sel, write, read, enable, busy, shape_done, shape_err;
  logic [SEL_W-1:0]      output_sel;
  logic [ARC_W-1:0]      arc_idx;

  int n_checks = 0, n_fail = 0;
  int cyc, wcnt, rcnt, dcnt, ecnt, outv, wr_first, wr_last;
  int sel_log [16];
  logic en_prev;

  always #5 clk = ~clk;

  shape_sequencer #(.SHAPE_ID_W(SHAPE_ID_W), .MAX_SIDES(MAX_SIDES), .NUM_ARCS(NUM_ARCS), .SEL_W(SEL_W)) dut (
    .clk(clk), .nreset(nreset), .new_shape(new_shape), .shapeid(shapeid), .num_sides(num_sides),
    .data_ready(data_ready), .data_sent(data_sent), .line_done(line_done), .arc_done(arc_done),
    .abort(abort), .prim_sel(prim_sel), .write(write), .read(read), .enable(enable),
    .output_sel(output_sel), .arc_idx(arc_idx), .busy(busy), .shape_done(shape_done), .shape_err(shape_err)
  );

  task automatic clear_tally;
    cyc = 0; wcnt = 0; rcnt = 0; dcnt = 0; ecnt = 0; outv = 0; wr_first = -1; wr_last = -1;
    en_prev = enable;
  endtask

  // advance one clock and tally the outputs of the new cycle
  task automatic step;
    @(posedge clk); #1;
    cyc++;
    if (write) begin
      if (wr_first < 0) wr_first = cyc;
      wr_last = cyc;
      if (wcnt < 16) sel_log[wcnt] = int'(output_sel);
      wcnt++;
    end
    if (read) rcnt++;
    if (shape_done) dcnt++;
    if (shape_err) ecnt++;
    if (en_prev && !enable && !read && busy) outv++;
    en_prev = enable;
  endtask

  task automatic start(input int id, input int sides);
    new_shape = 1'b1; shapeid = SHAPE_ID_W'(id); num_sides = SIDE_W'(sides);
    clear_tally;
    step;
    new_shape = 1'b0;
  endtask

  task automatic pixel(input int hold, output logic [ARC_W-1:0] arc_seen);
    data_ready = 1'b1; step; data_ready = 1'b0;
    arc_seen = arc_idx;
    repeat (hold) step;
    data_sent = 1'b1; step; data_sent = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int i = 0;
    while (busy && i < budget) begin step; i++; end
    ok = !busy;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({prim_sel, write, read, enable, output_sel, arc_idx, busy, shape_done, shape_err} !== 15'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want all zero", {prim_sel, write, read, enable, output_sel, arc_idx, busy, shape_done, shape_err});
    end
    nreset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_line;
    logic [ARC_W-1:0] a;
    start(0, 0);
    step;
    n_checks++;
    if (write !== 1'b1 || output_sel !== 4'd0) begin n_fail++; $display("FAIL line_push: write=%b sel=%0d want 1/0", write, output_sel); end
    step;
    n_checks++;
    if (enable !== 1'b1 || prim_sel !== 1'b0) begin n_fail++; $display("FAIL line_gen: enable=%b prim_sel=%b want 1/0", enable, prim_sel); end
    pixel(1, a);
    pixel(0, a);
    line_done = 1'b1; step; line_done = 1'b0;
    step;
    n_checks++;
    if (shape_done !== 1'b1) begin n_fail++; $display("FAIL line_done_pulse: shape_done=%b want 1", shape_done); end
    step;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL line_idle: busy=%b want 0", busy); end
    n_checks++;
    if (wcnt !== 1 || wr_first !== 2) begin n_fail++; $display("FAIL line_writes: count=%0d first=%0d want 1/2", wcnt, wr_first); end
    n_checks++;
    if (outv !== 2 || rcnt !== 1 || dcnt !== 1) begin n_fail++; $display("FAIL line_counts: out=%0d reads=%0d done=%0d want 2/1/1", outv, rcnt, dcnt); end
  endtask

  task automatic test_polygon;
    logic [ARC_W-1:0] a;
    bit ok;
    start(1, 5);
    repeat (5) step;
    step;
    for (int s = 0; s < 5; s++) begin
      if (s == 0) begin new_shape = 1'b1; shapeid = 4'd7; end
      pixel(0, a);
      new_shape = 1'b0;
      line_done = 1'b1; step; line_done = 1'b0;
      step;
    end
    wait_idle(10, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL poly_timeout: busy=%b want 0", busy); end
    n_checks++;
    if (wcnt !== 5 || wr_first !== 2 || wr_last !== 6) begin n_fail++; $display("FAIL poly_writes: count=%0d first=%0d last=%0d want 5/2/6", wcnt, wr_first, wr_last); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (sel_log[i] !== i) begin n_fail++; $display("FAIL poly_sel[%0d]: got %0d want %0d", i, sel_log[i], i); end
    end
    n_checks++;
    if (rcnt !== 5 || dcnt !== 1 || ecnt !== 0) begin n_fail++; $display("FAIL poly_counts: reads=%0d done=%0d err=%0d want 5/1/0", rcnt, dcnt, ecnt); end
  endtask

  task automatic test_circle;
    logic [ARC_W-1:0] a;
    start(3, 0);
    step;
    step;
    n_checks++;
    if (prim_sel !== 1'b1 || enable !== 1'b1) begin n_fail++; $display("FAIL circ_gen: prim_sel=%b enable=%b want 1/1", prim_sel, enable); end
    for (int i = 0; i < 10; i++) begin
      pixel(0, a);
      n_checks++;
      if (a !== ARC_W'(i % NUM_ARCS)) begin n_fail++; $display("FAIL circ_arc[%0d]: got %0d want %0d", i, a, i % NUM_ARCS); end
    end
    arc_done = 1'b1; step; arc_done = 1'b0;
    n_checks++;
    if (enable !== 1'b1 || read !== 1'b0 || arc_idx !== 3'd2) begin n_fail++; $display("FAIL circ_early_done: enable=%b read=%b arc=%0d want 1/0/2", enable, read, arc_idx); end
    for (int i = 0; i < 6; i++) pixel(0, a);
    n_checks++;
    if (arc_idx !== 3'd0) begin n_fail++; $display("FAIL circ_wrap: arc=%0d want 0", arc_idx); end
    arc_done = 1'b1; step; arc_done = 1'b0;
    n_checks++;
    if (read !== 1'b1) begin n_fail++; $display("FAIL circ_pop: read=%b want 1", read); end
    step;
    step;
    n_checks++;
    if (busy !== 1'b0 || rcnt !== 1 || dcnt !== 1 || wcnt !== 1) begin
      n_fail++; $display("FAIL circ_counts: busy=%b reads=%0d done=%0d writes=%0d want 0/1/1/1", busy, rcnt, dcnt, wcnt);
    end
  endtask

  task automatic test_illegal;
    int ids [3] = '{7, 1, 1};
    int sds [3] = '{0, 2, 9};
    for (int k = 0; k < 3; k++) begin
      start(ids[k], sds[k]);
      step;
      n_checks++;
      if (shape_err !== 1'b1) begin n_fail++; $display("FAIL illegal_err[%0d]: shape_err=%b want 1", k, shape_err); end
      step;
      n_checks++;
      if (busy !== 1'b0 || wcnt !== 0 || ecnt !== 1 || dcnt !== 0) begin
        n_fail++; $display("FAIL illegal_end[%0d]: busy=%b writes=%0d err=%0d done=%0d want 0/0/1/0", k, busy, wcnt, ecnt, dcnt);
      end
    end
  endtask

  task automatic test_abort;
    bit ok;
    start(1, 5);
    repeat (5) step;
    step;
    line_done = 1'b1; step; line_done = 1'b0;
    step;
    clear_tally;
    abort = 1'b1; step; abort = 1'b0;
    wait_idle(20, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_timeout: busy=%b want 0", busy); end
    n_checks++;
    if (rcnt !== 4 || dcnt !== 0 || ecnt !== 0 || wcnt !== 0) begin
      n_fail++; $display("FAIL abort_drain: reads=%0d done=%0d err=%0d writes=%0d want 4/0/0/0", rcnt, dcnt, ecnt, wcnt);
    end
  endtask

  task automatic test_async_reset;
    logic [ARC_W-1:0] a;
    bit ok;
    start(3, 0);
    step;
    step;
    for (int i = 0; i < 3; i++) pixel(0, a);
    data_ready = 1'b1; step; data_ready = 1'b0;
    #2 nreset = 1'b0;
    #1;
    n_checks++;
    if ({prim_sel, write, read, enable, output_sel, arc_idx, busy, shape_done, shape_err} !== 15'd0) begin
      n_fail++; $display("FAIL async_reset: got %b want all zero", {prim_sel, write, read, enable, output_sel, arc_idx, busy, shape_done, shape_err});
    end
    repeat (2) step;
    nreset = 1'b1;
    step;
    start(0, 0);
    step;
    step;
    line_done = 1'b1; step; line_done = 1'b0;
    wait_idle(10, ok);
    n_checks++;
    if (!ok || dcnt !== 1 || wcnt !== 1 || rcnt !== 1) begin
      n_fail++; $display("FAIL post_reset_shape: idle=%0b done=%0d writes=%0d reads=%0d want 1/1/1/1", ok, dcnt, wcnt, rcnt);
    end
  endtask

  initial begin
    test_reset;
    test_line;
    test_polygon;
    test_circle;
    test_illegal;
    test_abort;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
